// File: rtl/disp_pkg.sv
// Shared types and constants for the display page scheduler.
package disp_pkg;

   localparam int PAGE_W    = 3;
   localparam int NUM_PAGES = 8;
   localparam int NUM_SRC   = 4;
   localparam int SRC_W     = 32;
   localparam int DISP_W    = 16;

   typedef logic [PAGE_W-1:0] page_t;

   typedef enum logic [1:0] {
      SHOW,
      SEEK,
      EMPTY
   } state_e;

   localparam logic [DISP_W-1:0] BLANK_DATA = 16'h0000;
   localparam page_t DIR_FWD   = 3'd1;
   localparam page_t DIR_BWD   = 3'd7;  // -1 in page arithmetic
   localparam page_t LAST_STEP = PAGE_W'(NUM_PAGES - 1);

   // Page p shows source p>>1; even pages take the upper half-word, which sits
   // in 16-bit slot {p[2:1], 1}, odd pages the lower one in slot {p[2:1], 0}.
   function automatic logic [DISP_W-1:0] page_word(
      input logic [NUM_SRC*SRC_W-1:0] data,
      input page_t                    p
   );
      return data[{p[2:1], ~p[0], 4'b0000} +: DISP_W];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for one raw switch or button.
// EDGE_OUT selects whether out_o is the accepted level or its rising-edge pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 1000000,
   parameter bit EDGE_OUT     = 1'b1
) (
   input  logic clk,
   input  logic clr_n,
   input  logic raw_i,
   output logic out_o
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             rise_q;
   logic [CNT_W-1:0] cnt_q;

   // NOTE: non-blocking assignments let every flop sample the pre-edge value,
   // which is what makes sync1_q -> sync2_q a real two-stage synchronizer.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         rise_q  <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            level_q <= sync2_q;
            rise_q  <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign out_o = EDGE_OUT ? rise_q : level_q;

endmodule

// File: rtl/disp_page_sched.sv
// Chooses which 16-bit page of the CPU debug sources the 7-seg display shows,
// stepping on debounced buttons or an auto-scroll timer and skipping invalid sources.
module disp_page_sched
   import disp_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int DWELL_CYC    = 100000000
) (
   input  logic                     clk,
   input  logic                     clr_n,
   input  logic                     btn_next,
   input  logic                     btn_prev,
   input  logic                     auto_en,
   input  logic [NUM_SRC*SRC_W-1:0] src_data,
   input  logic [NUM_SRC-1:0]       src_valid,
   output logic [DISP_W-1:0]        disp_data,
   output logic [PAGE_W-1:0]        page,
   output logic                     page_strobe,
   output logic                     empty
);

   localparam int DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYC - 1);

   logic              next_evt;
   logic              prev_evt;
   logic              auto_lvl;

   state_e            state_q;
   page_t             page_q;
   page_t             dir_q;
   page_t             start_q;
   page_t             step_q;
   logic [DW_W-1:0]   dwell_q;
   logic [DISP_W-1:0] disp_q;
   logic              strobe_q;
   logic              empty_q;

   page_t             cand;
   logic              dwell_last;
   logic              seek_go;
   page_t             seek_dir;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .EDGE_OUT(1'b1)) u_next (
      .clk   (clk),
      .clr_n (clr_n),
      .raw_i (btn_next),
      .out_o (next_evt)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .EDGE_OUT(1'b1)) u_prev (
      .clk   (clk),
      .clr_n (clr_n),
      .raw_i (btn_prev),
      .out_o (prev_evt)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .EDGE_OUT(1'b0)) u_auto (
      .clk   (clk),
      .clr_n (clr_n),
      .raw_i (auto_en),
      .out_o (auto_lvl)
   );

   assign cand       = page_q + dir_q;
   assign dwell_last = (dwell_q == DWELL_LAST);

   // NOTE: every output of an always_comb gets a default first, so no path
   // through the case can leave it unassigned and infer a latch.
   always_comb begin
      seek_go  = 1'b0;
      seek_dir = DIR_FWD;
      unique case (state_q)
         SHOW: begin
            if (!src_valid[page_q[2:1]]) begin
               seek_go = 1'b1;
            end else if (next_evt ^ prev_evt) begin
               seek_go  = 1'b1;
               seek_dir = next_evt ? DIR_FWD : DIR_BWD;
            end else if (!next_evt && auto_lvl && dwell_last) begin
               seek_go = 1'b1;
            end
         end
         EMPTY:   seek_go = |src_valid;
         default: seek_go = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q  <= SHOW;
         page_q   <= '0;
         dir_q    <= DIR_FWD;
         start_q  <= '0;
         step_q   <= '0;
         dwell_q  <= '0;
         disp_q   <= BLANK_DATA;
         strobe_q <= 1'b0;
         empty_q  <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         disp_q   <= (state_q == EMPTY) ? BLANK_DATA : page_word(src_data, page_q);
         unique case (state_q)
            SHOW, EMPTY: begin
               if (seek_go) begin
                  state_q <= SEEK;
                  dir_q   <= seek_dir;
                  start_q <= page_q;
                  step_q  <= '0;
                  dwell_q <= '0;
                  empty_q <= 1'b0;
               end else if (state_q == SHOW) begin
                  dwell_q <= (!auto_lvl || dwell_last) ? '0 : dwell_q + 1'b1;
               end
            end
            SEEK: begin
               page_q <= cand;
               if (src_valid[cand[2:1]]) begin
                  state_q  <= SHOW;
                  dwell_q  <= '0;
                  // A full lap back to the start page is not a page change.
                  strobe_q <= (cand != start_q);
               end else if (step_q == LAST_STEP) begin
                  state_q <= EMPTY;
                  page_q  <= start_q;
                  empty_q <= 1'b1;
               end else begin
                  step_q <= step_q + 1'b1;
               end
            end
            default: state_q <= SHOW;
         endcase
      end
   end

   assign disp_data   = disp_q;
   assign page        = page_q;
   assign page_strobe = strobe_q;
   assign empty       = empty_q;

endmodule

// File: tb/tb_disp_page_sched.sv
// Scoreboard bench for disp_page_sched: stimulus queues the expected page/data
// for every page change, a monitor checks them whenever page_strobe fires.
module tb_disp_page_sched;

   localparam int DEB   = 4;
   localparam int DWELL = 16;

   typedef struct {
      logic [2:0]  page;
      logic [15:0] data;
   } exp_t;

   logic         clk;
   logic         clr_n;
   logic         btn_next;
   logic         btn_prev;
   logic         auto_en;
   logic [127:0] src_data;
   logic [3:0]   src_valid;
   logic [15:0]  disp_data;
   logic [2:0]   page;
   logic         page_strobe;
   logic         empty;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];

   // Hand-derived half-words for each page of the fixed source pattern below.
   logic [15:0] page_words [8] = '{16'h1A9B, 16'hC0DE, 16'h2222, 16'h3333,
                                   16'h4444, 16'h5555, 16'h6666, 16'h7777};

   disp_page_sched #(.DEBOUNCE_CYC(DEB), .DWELL_CYC(DWELL)) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .btn_next    (btn_next),
      .btn_prev    (btn_prev),
      .auto_en     (auto_en),
      .src_data    (src_data),
      .src_valid   (src_valid),
      .disp_data   (disp_data),
      .page        (page),
      .page_strobe (page_strobe),
      .empty       (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic push(input logic [2:0] p);
      exp_t e;
      e.page = p;
      e.data = page_words[p];
      sb.push_back(e);
   endtask

   task automatic press(input logic nxt, input logic prv);
      @(negedge clk);
      btn_next = nxt;
      btn_prev = prv;
      repeat (10) @(negedge clk);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic wait_strobe(input int max_cyc, input string name, output int t);
      t = -1;
      for (int n = 0; n < max_cyc; n++) begin
         @(negedge clk);
         if (page_strobe) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=no strobe required=strobe within %0d cycles", name, max_cyc);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (clr_n && page_strobe) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL strobe_unexpected actual page=%0d required no strobe", page);
            end else begin
               e = sb.pop_front();
               check("strobe_page", 32'(page), 32'(e.page));
               @(negedge clk);
               check("strobe_disp", 32'(disp_data), 32'(e.data));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int t1, t2, t3, t4, t5, lat;
      clr_n     = 1'b0;
      btn_next  = 1'b0;
      btn_prev  = 1'b0;
      auto_en   = 1'b0;
      src_valid = 4'hF;
      src_data  = {32'h6666_7777, 32'h4444_5555, 32'h2222_3333, 32'h1A9B_C0DE};
      repeat (3) @(negedge clk);
      clr_n = 1'b1;
      repeat (3) @(negedge clk);

      // Start a seek from page 0 and cut it short with reset.
      src_valid = 4'b1000;
      repeat (3) @(posedge clk);
      #1 clr_n = 1'b0;
      #1;
      check("rst_page", 32'(page), 32'd0);
      check("rst_disp", 32'(disp_data), 32'h0000);
      check("rst_strobe", 32'(page_strobe), 32'd0);
      check("rst_empty", 32'(empty), 32'd0);
      @(negedge clk);
      src_valid = 4'hF;
      clr_n     = 1'b1;
      @(negedge clk);
      check("rst_first_disp", 32'(disp_data), 32'h1A9B);

      // Bouncing button must not be accepted.
      for (int i = 0; i < 10; i++) begin
         btn_next = ~btn_next;
         repeat (2) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("bounce_page", 32'(page), 32'd0);

      push(3'd1);
      press(1'b1, 1'b0);
      check("next_page", 32'(page), 32'd1);

      // Skip invalid sources 1 and 2, then wrap both ways.
      src_valid = 4'b1001;
      push(3'd6);
      press(1'b1, 1'b0);
      check("skip_page", 32'(page), 32'd6);
      push(3'd7);
      press(1'b1, 1'b0);
      check("step_page", 32'(page), 32'd7);
      push(3'd0);
      press(1'b1, 1'b0);
      check("wrap_fwd_page", 32'(page), 32'd0);
      push(3'd7);
      press(1'b0, 1'b1);
      check("wrap_bwd_page", 32'(page), 32'd7);

      // Auto-scroll 7->0->1->2, manual next to 3, auto again to 4.
      src_valid = 4'hF;
      push(3'd0);
      push(3'd1);
      push(3'd2);
      push(3'd3);
      push(3'd4);
      auto_en = 1'b1;
      wait_strobe(60, "auto_first", t1);
      wait_strobe(40, "auto_second", t2);
      wait_strobe(40, "auto_third", t3);
      check_range("auto_interval_a", t2 - t1, DWELL, DWELL + 1);
      check_range("auto_interval_b", t3 - t2, DWELL, DWELL + 1);
      repeat (3) @(negedge clk);
      btn_next = 1'b1;
      wait_strobe(20, "manual_in_auto", t4);
      btn_next = 1'b0;
      wait_strobe(40, "auto_after_manual", t5);
      check_range("dwell_restart", t5 - t4, DWELL, DWELL + 1);
      auto_en = 1'b0;
      repeat (40) @(negedge clk);
      check("auto_off_page", 32'(page), 32'd4);

      // All sources invalid: full lap then EMPTY with page held.
      src_valid = 4'b0000;
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (empty) begin
            lat = i;
            break;
         end
      end
      check_range("empty_latency", lat, 1, 9);
      @(negedge clk);
      check("empty_disp", 32'(disp_data), 32'h0000);
      check("empty_page", 32'(page), 32'd4);
      check("empty_flag", 32'(empty), 32'd1);

      push(3'd5);
      src_valid = 4'b0100;
      repeat (5) @(negedge clk);
      check("recover_empty", 32'(empty), 32'd0);
      check("recover_page", 32'(page), 32'd5);

      // Simultaneous next and prev events cancel.
      src_valid = 4'hF;
      press(1'b1, 1'b1);
      check("both_page", 32'(page), 32'd5);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/disp_page_sched.md
Name: disp_page_sched

Overview:
Scheduler that decides which CPU datum the 4-digit 7-seg display shows. It multiplexes four 32-bit debug sources (PC, instruction, register read data, ALU result) into 8 16-bit pages. It drives the 16-bit disp_data input of the display scan register. Page changes come from debounced next/prev buttons or an auto-scroll timer, and pages whose source is not valid are skipped.

Parameters:
DEBOUNCE_CYC, 1000000, clk cycles a synchronized button level must stay stable before it is accepted
DWELL_CYC, 100000000, clk cycles each page is shown in auto-scroll mode
NUM_PAGES, 8, page count; fixed at 2 pages per source; not overridable

Ports:
clk  in  1  system clock
clr_n  in  1  asynchronous active-low reset
btn_next  in  1  raw push-button, asynchronous, bouncing
btn_prev  in  1  raw push-button, asynchronous, bouncing
auto_en  in  1  raw slide switch; 1 = auto-scroll
src_data  in  128  {src3,src2,src1,src0}, 32 bits each
src_valid  in  4  per-source valid; an invalid source's pages are skipped
disp_data  out  16  value to the display scan register
page  out  3  current page index
page_strobe  out  1  one-cycle pulse when page changes
empty  out  1  1 when no source is valid

Behaviour:
- Reset (clr_n low, asynchronous, any state, including mid-seek): page=0, disp_data=16'h0000, page_strobe=0, empty=0, state=SHOW, dwell counter=0, debounce state cleared.
- Input conditioning:
  - btn_next, btn_prev and auto_en each pass through a 2-FF synchronizer, then a debouncer.
  - The debouncer accepts the new level only after DEBOUNCE_CYC consecutive equal samples.
  - A button event is a single-cycle pulse on the accepted 0->1 edge.
- Page mapping: page p selects source p>>1. p[0]=0 gives bits [31:16]; p[0]=1 gives bits [15:0].
- disp_data is registered, 1-cycle latency, and tracks live src_data in SHOW.
- FSM states:
  - SHOW:
    - next event -> SEEK with dir=+1.
    - prev event -> SEEK with dir=-1.
    - next and prev in the same cycle: both dropped, stay in SHOW.
    - auto_en accepted high and dwell counter == DWELL_CYC-1 -> SEEK with dir=+1.
    - src_valid[page>>1]==0 -> SEEK with dir=+1.
  - SEEK:
    - Each cycle cand = page+dir mod 8; 3-bit wrap: 7+1=0, 0-1=7.
    - cand becomes page; step count increments.
    - If src_valid[cand>>1]: go to SHOW, pulse page_strobe, clear dwell counter.
    - After 8 candidates without a hit: go to EMPTY with page unchanged from its value at SEEK entry.
    - Button events arriving during SEEK are dropped.
  - EMPTY:
    - disp_data=16'h0000, empty=1.
    - Any src_valid bit set -> SEEK with dir=+1.
- Dwell counter:
  - Counts only in SHOW with auto_en high; wraps at DWELL_CYC-1.
  - Cleared on every page change and whenever auto_en is low.
- page_strobe is never asserted if the page value does not change, e.g. a seek that returns to the start page.
- Latency:
  - Button: raw edge -> event pulse in 2+DEBOUNCE_CYC+1 cycles.
  - Event -> new page: 1 cycle per seek step (minimum 1, maximum 8).
  - New page -> disp_data: 1 cycle.

Decomposition:
- Package disp_pkg:
  - state enum {SHOW, SEEK, EMPTY}
  - PAGE_W=3, NUM_PAGES=8, NUM_SRC=4
  - BLANK_DATA=16'h0000
  - DIR_FWD/DIR_BWD constants
- Sub-module btn_debounce: synchronizer, stable counter, accepted level, rise pulse. Parameter DEBOUNCE_CYC.
  - Instantiated 3 times: next, prev, auto_en. The pulse output is unused for auto_en.

Test Plan (DEBOUNCE_CYC=4, DWELL_CYC=16):
- Reset:
  - Stimulus: clr_n pulsed low during a seek.
  - Response: page=0, disp_data=0, page_strobe=0 immediately.
  - Stimulus: release with src_valid=4'hF, src0=32'h1A9B_C0DE.
  - Response: disp_data=16'h1A9B one cycle later.
- Bounce and debounce:
  - Stimulus: btn_next toggled every 2 cycles for 20 cycles.
  - Response: page stays 0.
  - Stimulus: btn_next held high 10 cycles.
  - Response: page=1, page_strobe high for exactly 1 cycle, disp_data=16'hC0DE.
- Skip and wrap:
  - Stimulus: src_valid=4'b1001, page=1, next event.
  - Response: page=6 after 5 seek cycles.
  - Stimulus: prev event at page 0.
  - Response: page=7 after 1 cycle.
- Auto-scroll:
  - Stimulus: auto_en=1, src_valid=4'hF.
  - Response: page advances every 16 cycles; 7->0 wraps; a manual next restarts the dwell count.
- Empty:
  - Stimulus: src_valid=0.
  - Response: empty=1 within 9 cycles, disp_data=16'h0000, page held.
  - Stimulus: src_valid=4'b0100.
  - Response: page=4 or 5, whichever is first forward; empty=0; strobe pulses once.
- Simultaneous:
  - Stimulus: next and prev events in the same cycle.
  - Response: page and page_strobe unchanged.
